mram_access_arbiter: RTL and testbench
======================================

# mram_access_arbiter

Shares the single asynchronous MRAM device bus between two requesters (port 0: SPI command path, port 1: internal test/scrub engine) and generates the MRAM control strobe sequence (setup, strobe pulse, hold) from programmable cycle counts. It sits between the SPI slave front end and the MRAM pins. It replaces ad-hoc delay counting in requesters with a single req/done handshake per access.

## Interface
- SETUP_CYCLES, 1: cycles with address/CE valid before strobe (1–15)
- PULSE_CYCLES, 4: read_en/write_en low width (1–15)
- HOLD_CYCLES, 1: cycles after strobe release with address/data held (1–15)
- FPGA_clk  in  1  system clock, all logic on rising edge
- FPGA_rst_n  in  1  asynchronous, active-low reset
- pN_req  in  1  access request, N∈{0,1}; held with fields stable until pN_done
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  20  word address
- pN_wdata  in  16  write data
- pN_be  in  2  byte enables, [0]=lower byte, [1]=upper byte
- pN_done  out  1  one-cycle completion pulse
- pN_rdata  out  16  read data, valid with pN_done, held until next pN_done
- busy  out  1  high in any state other than IDLE
- chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out  out  1 each  MRAM controls, active-low
- addr_line  out  20  MRAM address
- data_line  out  16  write data toward pad
- data_oe  out  1  pad output enable (writes only)
- data_in  in  16  read data from pad

## Operation
- Reset values: all five *_en_out = 1, addr_line = 0, data_line = 0, data_oe = 0, pN_done = 0, pN_rdata = 0, busy = 0, state IDLE, last-grant = port 1.
- States: IDLE → SETUP → PULSE → HOLD → DONE → IDLE. No other transitions.
- IDLE: arbitrate when any req high; latch winner's we/addr/wdata/be into internal registers; go SETUP. Requester fields are ignored after latch.
- Arbitration: single request wins; simultaneous requests go to the port not granted last; update last-grant on grant.
- SETUP: chip_en_out=0, addr_line = latched addr, lb/ub_en_out = ~be; writes drive data_line and data_oe=1.
- PULSE: as SETUP plus write_en_out=0 (write) or read_en_out=0 (read). For reads, data_in is captured at the edge leaving PULSE; lanes with be bit 0 capture 8'h00.
- HOLD: strobes back to 1; chip_en, address, lanes, data, data_oe unchanged.
- DONE: chip_en_out=1, lanes=1, data_oe=0; pulse granted port's pN_done; update pN_rdata (reads only; writes leave pN_rdata unchanged).
- be=2'b00: full cycle runs with lb/ub_en_out=1; done issued; read returns 16'h0000.
- Per-state cycle counter is 4 bits, reloaded on entry to each state. Out-of-range parameters are a compile-time error.

## Timing
- Request sampled high at edge 0 → pN_done high in cycle 1+SETUP+PULSE+HOLD. This is cycle 7 with defaults.
- Minimum access period is SETUP+PULSE+HOLD+2 cycles, with one mandatory IDLE cycle. A requester that drops req on the edge after done is not re-granted.
- req held high in the IDLE cycle after its own done counts as a new request.
- Deassertion of req after grant has no effect; the access completes.
- Reset asserted mid-access: outputs return to reset values asynchronously; no done is issued. The requester must reissue.

## Configuration
- MRAM_ARB_ROUND_ROBIN_EN defined: last-grant fairness as above.
- Not defined: fixed priority; port 0 always wins simultaneous requests, and the last-grant register is removed.

## Structure
- Package mram_arb_pkg holds: ADDR_W=20, DATA_W=16, state enum (IDLE, SETUP, PULSE, HOLD, DONE), default timing constants.
- Sub-module mram_rr_arbiter: 2-way grant logic with the last-grant register and a macro-selected fixed-priority mode.

## Test plan
- p0 write addr 20'h00010, wdata 16'hA5C3, be 2'b11 → chip_en low cycles 1–6, write_en low cycles 2–5, data_oe high cycles 1–6, p0_done in cycle 7.
- p1 read addr 20'hFFFFF with data_in 16'h1234, be 2'b01 → read_en low cycles 2–5, ub_en_out=1, p1_rdata 16'h0034 with p1_done.
- p0 and p1 both request from reset → p0 granted first, p1 second; p1 done exactly 8 cycles after p0 done. Repeat with both held → alternation. Without macro → p0 wins every time.
- Custom SETUP=2/PULSE=1/HOLD=3 → done in cycle 7, strobe one cycle wide.
- Assert FPGA_rst_n low during PULSE of a write → all controls 1 and data_oe 0 immediately, no done, next request from IDLE proceeds normally.
- be=2'b00 read → lb/ub stay 1 through the cycle, rdata 16'h0000, done on normal cycle.

Source files
------------

// File: rtl/mram_arb_pkg.sv
// Shared widths, FSM state encoding and default strobe timing for the MRAM access arbiter.
package mram_arb_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;

  localparam int unsigned DEF_SETUP_CYCLES = 1;
  localparam int unsigned DEF_PULSE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StDone
  } state_e;

  // Expands byte enables to a per-bit lane mask; disabled lanes read back as zero.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/mram_rr_arbiter.sv
// Two-way grant selection. MRAM_ARB_ROUND_ROBIN_EN enables last-grant fairness;
// otherwise port 0 has fixed priority and no state is kept.
module mram_rr_arbiter (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req0_i,
  input  logic req1_i,
  input  logic grant_i,
  output logic gnt_port_o
);

`ifdef MRAM_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    if (req0_i && req1_i) begin
      gnt_port_o = ~last_q;
    end else begin
      gnt_port_o = ~req0_i;
    end
    last_d = grant_i ? gnt_port_o : last_q;
  end

  // Reset favours port 0 on the first contended grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  logic unused_fixed;

  assign gnt_port_o   = ~req0_i;
  assign unused_fixed = ^{clk_i, rst_ni, req1_i, grant_i};
`endif

endmodule

// File: rtl/mram_access_arbiter.sv
// Arbitrates two requesters onto one asynchronous MRAM bus and sequences setup/strobe/hold.
// Build option: MRAM_ARB_ROUND_ROBIN_EN selects last-grant fairness over fixed priority.
module mram_access_arbiter
  import mram_arb_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES
) (
  input  logic              FPGA_clk,
  input  logic              FPGA_rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [1:0]        p0_be,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [1:0]        p1_be,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              busy,
  output logic              chip_en_out,
  output logic              read_en_out,
  output logic              write_en_out,
  output logic              lb_en_out,
  output logic              ub_en_out,
  output logic [ADDR_W-1:0] addr_line,
  output logic [DATA_W-1:0] data_line,
  output logic              data_oe,
  input  logic [DATA_W-1:0] data_in
);

  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15 || PULSE_CYCLES < 1 || PULSE_CYCLES > 15 ||
      HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_timing
    $error("mram_access_arbiter: timing parameters must be within 1..15");
  end

  localparam logic [3:0] SetupLd = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] PulseLd = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] HoldLd  = 4'(HOLD_CYCLES - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                port_q, port_d;
  logic                we_q, we_d;
  logic [1:0]          be_q, be_d;
  logic [DATA_W-1:0]   rcap_q, rcap_d;
  logic                ce_q, ce_d, re_q, re_d, wr_q, wr_d, lb_q, lb_d, ub_q, ub_d, oe_q, oe_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dline_q, dline_d;
  logic [1:0]          done_q, done_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                grant, gnt_port;
  logic                g_we;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic [1:0]          g_be;

  assign grant = (state_q == StIdle) && (p0_req || p1_req);

  mram_rr_arbiter u_arb (
    .clk_i      (FPGA_clk),
    .rst_ni     (FPGA_rst_n),
    .req0_i     (p0_req),
    .req1_i     (p1_req),
    .grant_i    (grant),
    .gnt_port_o (gnt_port)
  );

  always_comb begin
    g_we    = gnt_port ? p1_we    : p0_we;
    g_addr  = gnt_port ? p1_addr  : p0_addr;
    g_wdata = gnt_port ? p1_wdata : p0_wdata;
    g_be    = gnt_port ? p1_be    : p0_be;
  end

  // Outputs are registered: each transition loads the pin values of the state being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    port_d   = port_q;
    we_d     = we_q;
    be_d     = be_q;
    rcap_d   = rcap_q;
    ce_d     = ce_q;
    re_d     = re_q;
    wr_d     = wr_q;
    lb_d     = lb_q;
    ub_d     = ub_q;
    oe_d     = oe_q;
    addr_d   = addr_q;
    dline_d  = dline_q;
    done_d   = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StSetup;
          cnt_d   = SetupLd;
          port_d  = gnt_port;
          we_d    = g_we;
          be_d    = g_be;
          ce_d    = 1'b0;
          addr_d  = g_addr;
          lb_d    = ~g_be[0];
          ub_d    = ~g_be[1];
          if (g_we) begin
            dline_d = g_wdata;
            oe_d    = 1'b1;
          end
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StPulse;
          cnt_d   = PulseLd;
          wr_d    = ~we_q;
          re_d    = we_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPulse: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          cnt_d   = HoldLd;
          wr_d    = 1'b1;
          re_d    = 1'b1;
          if (!we_q) begin
            rcap_d = data_in & lane_mask(be_q);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          ce_d    = 1'b1;
          lb_d    = 1'b1;
          ub_d    = 1'b1;
          oe_d    = 1'b0;
          done_d  = port_q ? 2'b10 : 2'b01;
          if (!we_q) begin
            if (port_q) begin
              rdata1_d = rcap_q;
            end else begin
              rdata0_d = rcap_q;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
    if (!FPGA_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      rcap_q   <= '0;
      ce_q     <= 1'b1;
      re_q     <= 1'b1;
      wr_q     <= 1'b1;
      lb_q     <= 1'b1;
      ub_q     <= 1'b1;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      dline_q  <= '0;
      done_q   <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      port_q   <= port_d;
      we_q     <= we_d;
      be_q     <= be_d;
      rcap_q   <= rcap_d;
      ce_q     <= ce_d;
      re_q     <= re_d;
      wr_q     <= wr_d;
      lb_q     <= lb_d;
      ub_q     <= ub_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      dline_q  <= dline_d;
      done_q   <= done_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign chip_en_out  = ce_q;
  assign read_en_out  = re_q;
  assign write_en_out = wr_q;
  assign lb_en_out    = lb_q;
  assign ub_en_out    = ub_q;
  assign addr_line    = addr_q;
  assign data_line    = dline_q;
  assign data_oe      = oe_q;
  assign p0_done      = done_q[0];
  assign p1_done      = done_q[1];
  assign p0_rdata     = rdata0_q;
  assign p1_rdata     = rdata1_q;

endmodule

// File: tb/tb_mram_access_arbiter.sv
// Directed bench for mram_access_arbiter: default timing instance plus a 2/1/3 timing instance.
module tb_mram_access_arbiter;

`ifdef MRAM_ARB_ROUND_ROBIN_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic        FPGA_clk = 1'b0;
  logic        FPGA_rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [19:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p0_wdata = '0, p1_wdata = '0;
  logic [1:0]  p0_be = 2'b00, p1_be = 2'b00;
  logic [15:0] data_in = '0;

  logic        p0_done, p1_done, busy, chip_en_out, read_en_out, write_en_out;
  logic        lb_en_out, ub_en_out, data_oe;
  logic [15:0] p0_rdata, p1_rdata, data_line;
  logic [19:0] addr_line;

  logic        c_req = 1'b0, c_p1_req = 1'b0;
  logic        c_p0_done, c_p1_done, c_busy, c_ce, c_re, c_wr, c_lb, c_ub, c_oe;
  logic [15:0] c_p0_rdata, c_p1_rdata, c_dline;
  logic [19:0] c_addr;

  int checks = 0;
  int failures = 0;

  logic [7:0]  tr [64];
  logic [7:0]  ctr [64];
  logic [19:0] at_tr [64];
  logic [15:0] dl_tr [64];
  logic [15:0] rd0_tr [64];
  logic [15:0] rd1_tr [64];
  logic        busy_tr [64];

  mram_access_arbiter dut (
    .FPGA_clk     (FPGA_clk),
    .FPGA_rst_n   (FPGA_rst_n),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_be        (p0_be),
    .p0_done      (p0_done),
    .p0_rdata     (p0_rdata),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_be        (p1_be),
    .p1_done      (p1_done),
    .p1_rdata     (p1_rdata),
    .busy         (busy),
    .chip_en_out  (chip_en_out),
    .read_en_out  (read_en_out),
    .write_en_out (write_en_out),
    .lb_en_out    (lb_en_out),
    .ub_en_out    (ub_en_out),
    .addr_line    (addr_line),
    .data_line    (data_line),
    .data_oe      (data_oe),
    .data_in      (data_in)
  );

  mram_access_arbiter #(
    .SETUP_CYCLES (2),
    .PULSE_CYCLES (1),
    .HOLD_CYCLES  (3)
  ) dut_c (
    .FPGA_clk     (FPGA_clk),
    .FPGA_rst_n   (FPGA_rst_n),
    .p0_req       (c_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_be        (p0_be),
    .p0_done      (c_p0_done),
    .p0_rdata     (c_p0_rdata),
    .p1_req       (c_p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_be        (p1_be),
    .p1_done      (c_p1_done),
    .p1_rdata     (c_p1_rdata),
    .busy         (c_busy),
    .chip_en_out  (c_ce),
    .read_en_out  (c_re),
    .write_en_out (c_wr),
    .lb_en_out    (c_lb),
    .ub_en_out    (c_ub),
    .addr_line    (c_addr),
    .data_line    (c_dline),
    .data_oe      (c_oe),
    .data_in      (data_in)
  );

  always #5 FPGA_clk = ~FPGA_clk;

  // Expected {ce, re, wr, oe, lb, ub, p0_done, p1_done} in cycle k after the grant edge.
  function automatic logic [7:0] exp_ctrl(input int k, input int s, input int p, input int h,
                                          input bit we, input logic [1:0] be, input bit port);
    logic acc, pul, dn;
    acc = (k >= 1) && (k <= s + p + h);
    pul = (k > s) && (k <= s + p);
    dn  = (k == s + p + h + 1);
    return {!acc, !(pul && !we), !(pul && we), acc && we,
            !(acc && be[0]), !(acc && be[1]), dn && !port, dn && port};
  endfunction

  task automatic start_req(input bit port, input bit we, input logic [19:0] addr,
                           input logic [15:0] wd, input logic [1:0] be);
    if (port) begin
      p1_we = we; p1_addr = addr; p1_wdata = wd; p1_be = be; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_addr = addr; p0_wdata = wd; p0_be = be; p0_req = 1'b1;
    end
  endtask

  task automatic trace(input int n, input bit drop);
    for (int k = 1; k <= n; k++) begin
      @(posedge FPGA_clk);
      #1;
      tr[k]      = {chip_en_out, read_en_out, write_en_out, data_oe, lb_en_out, ub_en_out,
                    p0_done, p1_done};
      ctr[k]     = {c_ce, c_re, c_wr, c_oe, c_lb, c_ub, c_p0_done, c_p1_done};
      at_tr[k]   = addr_line;
      dl_tr[k]   = data_line;
      rd0_tr[k]  = p0_rdata;
      rd1_tr[k]  = p1_rdata;
      busy_tr[k] = busy;
      if (drop) begin
        if (p0_done) p0_req = 1'b0;
        if (p1_done) p1_req = 1'b0;
        if (c_p0_done) c_req = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    FPGA_rst_n = 1'b0;
    repeat (2) @(posedge FPGA_clk);
    #1 FPGA_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge FPGA_clk);
    #1;
    checks++;
    if ({chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out} !== 5'b11111) begin
      failures++;
      $display("FAIL reset_ctrl: got %b want 11111",
               {chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out});
    end
    checks++;
    if ({addr_line, data_line, data_oe, busy} !== 38'd0) begin
      failures++;
      $display("FAIL reset_bus: addr %h data %h oe %b busy %b want all zero",
               addr_line, data_line, data_oe, busy);
    end
    checks++;
    if ({p0_done, p1_done, p0_rdata, p1_rdata} !== 34'd0) begin
      failures++;
      $display("FAIL reset_ports: done %b%b rdata %h %h want zero",
               p0_done, p1_done, p0_rdata, p1_rdata);
    end
    FPGA_rst_n = 1'b1;
  endtask

  task automatic test_write();
    start_req(1'b0, 1'b1, 20'h00010, 16'hA5C3, 2'b11);
    trace(9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (tr[k] !== exp_ctrl(k, 1, 4, 1, 1'b1, 2'b11, 1'b0)) begin
        failures++;
        $display("FAIL write_ctrl cycle %0d: got %b want %b", k, tr[k],
                 exp_ctrl(k, 1, 4, 1, 1'b1, 2'b11, 1'b0));
      end
    end
    checks++;
    if ({at_tr[1], dl_tr[3]} !== {20'h00010, 16'hA5C3}) begin
      failures++;
      $display("FAIL write_bus: addr %h data %h want 00010 a5c3", at_tr[1], dl_tr[3]);
    end
    checks++;
    if ({busy_tr[4], busy_tr[8]} !== 2'b10) begin
      failures++;
      $display("FAIL write_busy: got %b%b want 10", busy_tr[4], busy_tr[8]);
    end
  endtask

  task automatic test_read();
    data_in = 16'h1234;
    start_req(1'b1, 1'b0, 20'hFFFFF, 16'h0000, 2'b01);
    trace(9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (tr[k] !== exp_ctrl(k, 1, 4, 1, 1'b0, 2'b01, 1'b1)) begin
        failures++;
        $display("FAIL read_ctrl cycle %0d: got %b want %b", k, tr[k],
                 exp_ctrl(k, 1, 4, 1, 1'b0, 2'b01, 1'b1));
      end
    end
    checks++;
    if ({rd1_tr[6], rd1_tr[7], rd1_tr[9]} !== {16'h0000, 16'h0034, 16'h0034}) begin
      failures++;
      $display("FAIL read_rdata: got %h %h %h want 0000 0034 0034",
               rd1_tr[6], rd1_tr[7], rd1_tr[9]);
    end
    checks++;
    if ({at_tr[3], rd0_tr[7]} !== {20'hFFFFF, 16'h0000}) begin
      failures++;
      $display("FAIL read_addr: addr %h p0_rdata %h want fffff 0000", at_tr[3], rd0_tr[7]);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] want;
    do_reset();
    data_in = 16'hCAFE;
    start_req(1'b0, 1'b1, 20'h00100, 16'h1111, 2'b11);
    start_req(1'b1, 1'b0, 20'h00200, 16'h0000, 2'b11);
    trace(17, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      want = (k == 7) ? 2'b10 : (k == 15) ? 2'b01 : 2'b00;
      checks++;
      if (tr[k][1:0] !== want) begin
        failures++;
        $display("FAIL simul_done cycle %0d: got %b want %b", k, tr[k][1:0], want);
      end
    end
    checks++;
    if ({at_tr[9], rd1_tr[15]} !== {20'h00200, 16'hCAFE}) begin
      failures++;
      $display("FAIL simul_p1: addr %h rdata %h want 00200 cafe", at_tr[9], rd1_tr[15]);
    end
  endtask

  task automatic test_alternation();
    logic [1:0] want;
    int         cyc;
    start_req(1'b0, 1'b1, 20'h00300, 16'h2222, 2'b11);
    start_req(1'b1, 1'b0, 20'h00400, 16'h0000, 2'b11);
    trace(23, 1'b0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc  = 7 + 8 * i;
      want = (i == 1 && RrEn) ? 2'b01 : 2'b10;
      checks++;
      if (tr[cyc][1:0] !== want) begin
        failures++;
        $display("FAIL alternate_done cycle %0d: got %b want %b", cyc, tr[cyc][1:0], want);
      end
    end
    trace(2, 1'b0);
  endtask

  task automatic test_custom_timing();
    p0_we = 1'b1; p0_addr = 20'h00ABC; p0_wdata = 16'h3C3C; p0_be = 2'b11;
    c_req = 1'b1;
    trace(9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (ctr[k] !== exp_ctrl(k, 2, 1, 3, 1'b1, 2'b11, 1'b0)) begin
        failures++;
        $display("FAIL custom_ctrl cycle %0d: got %b want %b", k, ctr[k],
                 exp_ctrl(k, 2, 1, 3, 1'b1, 2'b11, 1'b0));
      end
    end
  endtask

  task automatic test_reset_mid();
    start_req(1'b0, 1'b1, 20'h00020, 16'h0F0F, 2'b11);
    trace(3, 1'b0);
    checks++;
    if (tr[3] !== 8'b0101_0000) begin
      failures++;
      $display("FAIL abort_pulse: got %b want 01010000", tr[3]);
    end
    #2 FPGA_rst_n = 1'b0;
    #1;
    checks++;
    if ({chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out, data_oe, busy}
        !== 7'b1111100) begin
      failures++;
      $display("FAIL abort_async: got %b want 1111100",
               {chip_en_out, read_en_out, write_en_out, lb_en_out, ub_en_out, data_oe, busy});
    end
    p0_req = 1'b0;
    trace(3, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (tr[k][1:0] !== 2'b00) begin
        failures++;
        $display("FAIL abort_nodone cycle %0d: got %b want 00", k, tr[k][1:0]);
      end
    end
    FPGA_rst_n = 1'b1;
    data_in = 16'h5A5A;
    start_req(1'b0, 1'b0, 20'h00030, 16'h0000, 2'b11);
    trace(9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (tr[k] !== exp_ctrl(k, 1, 4, 1, 1'b0, 2'b11, 1'b0)) begin
        failures++;
        $display("FAIL abort_retry cycle %0d: got %b want %b", k, tr[k],
                 exp_ctrl(k, 1, 4, 1, 1'b0, 2'b11, 1'b0));
      end
    end
    checks++;
    if (rd0_tr[7] !== 16'h5A5A) begin
      failures++;
      $display("FAIL abort_rdata: got %h want 5a5a", rd0_tr[7]);
    end
  endtask

  task automatic test_write_keeps_rdata();
    start_req(1'b0, 1'b1, 20'h00040, 16'h7777, 2'b10);
    trace(9, 1'b1);
    checks++;
    if (tr[3] !== exp_ctrl(3, 1, 4, 1, 1'b1, 2'b10, 1'b0)) begin
      failures++;
      $display("FAIL upper_lane: got %b want %b", tr[3], exp_ctrl(3, 1, 4, 1, 1'b1, 2'b10, 1'b0));
    end
    checks++;
    if ({tr[7][1:0], rd0_tr[7]} !== {2'b10, 16'h5A5A}) begin
      failures++;
      $display("FAIL write_keeps_rdata: done %b rdata %h want 10 5a5a", tr[7][1:0], rd0_tr[7]);
    end
  endtask

  task automatic test_be_zero();
    data_in = 16'hBEEF;
    start_req(1'b0, 1'b0, 20'h00050, 16'h0000, 2'b00);
    trace(9, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (tr[k] !== exp_ctrl(k, 1, 4, 1, 1'b0, 2'b00, 1'b0)) begin
        failures++;
        $display("FAIL be_zero_ctrl cycle %0d: got %b want %b", k, tr[k],
                 exp_ctrl(k, 1, 4, 1, 1'b0, 2'b00, 1'b0));
      end
    end
    checks++;
    if (rd0_tr[7] !== 16'h0000) begin
      failures++;
      $display("FAIL be_zero_rdata: got %h want 0000", rd0_tr[7]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_simultaneous();
    test_alternation();
    test_custom_timing();
    test_reset_mid();
    test_write_keeps_rdata();
    test_be_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
